// File: rtl/ahb_sram_slave.sv
// Purpose: AHB-Lite slave fronting a 2**MEM_AW x 32-bit SRAM; byte/half/word access; two-cycle ERROR response.
// Latency: OKAY data phase is WAIT_CYCLES+1 cycles with AHB_SLV_WAIT_STATE_EN defined, otherwise 1 cycle.
// Backpressure: HREADYOUT low in WAIT and ERR1; a new address phase is taken in IDLE/ACCESS/ERR2.
//
// Optional feature macro: AHB_SLV_WAIT_STATE_EN (builds the WAIT state and its down-counter).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HMASTLOCK/HWDATA/HREADY   AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP                                          AHB-Lite slave outputs
module ahb_sram_slave #(
    parameter int          MEM_AW      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef AHB_SLV_WAIT_STATE_EN
        ST_WAIT,
`endif
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [MEM_AW+1:0]   cap_addr;
    logic                cap_write;
    logic [2:0]          cap_size;
    logic [3:0]          byte_en;
    logic [31:0]         mem [0:DEPTH-1];

`ifdef AHB_SLV_WAIT_STATE_EN
    logic [3:0]          cnt;
    logic [3:0]          next_cnt;
`endif

    // BUSY is folded into IDLE and SEQ into NONSEQ, so only HTRANS[1] matters.
    logic accept;
    logic hit;
    logic size_ok;
    logic aligned;
    logic valid;

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign hit     = (HADDR[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
    assign size_ok = (HSIZE <= 3'b010);
    assign aligned = (HSIZE == 3'b001) ? ~HADDR[0] :
                     (HSIZE == 3'b010) ? (HADDR[1:0] == 2'b00) : 1'b1;
    assign valid   = hit & size_ok & aligned;

    // Burst type, lock and the SEQ/NONSEQ distinction carry no meaning for a single-cycle SRAM.
    logic unused_ok;
    assign unused_ok = &{1'b0, HBURST, HMASTLOCK, HTRANS[0], 4'(WAIT_CYCLES)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_size  <= '0;
`ifdef AHB_SLV_WAIT_STATE_EN
            cnt       <= '0;
`endif
        end else begin
            state <= next_state;
`ifdef AHB_SLV_WAIT_STATE_EN
            cnt   <= next_cnt;
`endif
            if (accept) begin
                cap_addr  <= HADDR[MEM_AW+1:0];
                cap_write <= HWRITE;
                cap_size  <= HSIZE;
            end
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        HREADYOUT  = 1'b1;
        HRESP      = 2'b00;
        HRDATA     = '0;
`ifdef AHB_SLV_WAIT_STATE_EN
        next_cnt   = cnt;
`endif
        case (state)
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 2'b01;
                next_state = ST_ERR2;
            end
`ifdef AHB_SLV_WAIT_STATE_EN
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 4'd0) begin
                    next_state = ST_ACCESS;
                end else begin
                    next_state = ST_WAIT;
                    next_cnt   = cnt - 4'd1;
                end
            end
`endif
            default: begin
                // IDLE, ACCESS and ERR2 all end a data phase and may take the next address.
                if (state == ST_ERR2) begin
                    HRESP = 2'b01;
                end
                if (state == ST_ACCESS && !cap_write) begin
                    HRDATA = mem[cap_addr[MEM_AW+1:2]];
                end
                if (accept) begin
                    if (!valid) begin
                        next_state = ST_ERR1;
                    end
`ifdef AHB_SLV_WAIT_STATE_EN
                    else if (WAIT_CYCLES > 0) begin
                        next_state = ST_WAIT;
                        next_cnt   = 4'(WAIT_CYCLES - 1);
                    end
`endif
                    else begin
                        next_state = ST_ACCESS;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (cap_size)
            3'b000:  byte_en = 4'b0001 << cap_addr[1:0];
            3'b001:  byte_en = 4'b0011 << cap_addr[1:0];
            default: byte_en = 4'b1111;
        endcase
    end

    // HWDATA is only valid in the data phase, so the write commits on the edge leaving ACCESS.
    // Reset on that edge drops the write; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_ACCESS && cap_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cap_addr[MEM_AW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Purpose: self-checking bench for ahb_sram_slave; transaction-level model predicts every data-phase cycle.
// Latency: model expects WS+1 cycles per OKAY transfer and 2 per ERROR transfer.
// Backpressure: HREADY is driven from the model's own view of when each data phase ends.
module tb_ahb_sram_slave;

`ifdef AHB_SLV_WAIT_STATE_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .MEM_AW      (10),
        .BASE_ADDR   (32'h2000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (hburst),
        .HTRANS    (htrans),
        .HMASTLOCK (hmastlock),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HRDATA    (hrdata),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp)
    );

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  gap;
    } xfer_t;

    int          checks   = 0;
    int          failures = 0;
    xfer_t       xq[$];
    logic [31:0] mem_m [0:1023];
    logic [31:0] last_rdata;
    logic [31:0] init_val4;
    logic [31:0] t5_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_valid(input xfer_t x);
        if ((x.addr >> 12) != 32'h0002_0000) return 1'b0;
        if (x.size > 3'd2) return 1'b0;
        return (x.addr % (32'd1 << x.size)) == 32'd0;
    endfunction

    task automatic model_write(input xfer_t x);
        int n;
        int off;
        int idx;
        n   = 1 << x.size;
        off = int'(x.addr % 4);
        idx = int'((x.addr % 4096) / 4);
        for (int i = 0; i < n; i++) begin
            mem_m[idx][8*(off+i) +: 8] = x.wdata[8*(off+i) +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input xfer_t x);
        return mem_m[int'((x.addr % 4096) / 4)];
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'b000;
        hburst = 3'b000;
    endtask

    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [1:0] gap);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.addr = addr;
        x.size = size; x.wdata = wdata; x.gap = gap;
        xq.push_back(x);
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int    k;
        k       = int'($urandom_range(0, 19));
        x.sel   = 1'b1;
        x.trans = 2'b10;
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = 3'($urandom_range(0, 2));
        x.addr  = 32'h2000_0000 + ($urandom_range(0, 31) * 4);
        if (x.size == 3'd0) x.addr = x.addr + $urandom_range(0, 3);
        if (x.size == 3'd1) x.addr = x.addr + 2 * $urandom_range(0, 1);
        if (k == 0) x.addr[31:28] = 4'h3;
        if (k == 1) x.size = 3'($urandom_range(3, 7));
        if (k == 2) begin x.size = 3'd2; x.addr[1:0] = 2'($urandom_range(1, 3)); end
        if (k == 3) x.trans = 2'b01;
        if (k == 4) x.sel = 1'b0;
        if (k == 5) x.trans = 2'b11;
        x.wdata = $urandom;
        x.gap   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
        return x;
    endfunction

    // Entered and left just after a rising edge. Each loop pass is one bus cycle.
    task automatic run_queue();
        int    guard;
        int    gap;
        int    dp_cnt;
        int    dp_len;
        bit    dp_act;
        bit    dp_ok;
        bit    present;
        bit    fin;
        xfer_t dp;
        xfer_t x;
        logic        exp_rdy;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        guard = 0; gap = 0; dp_cnt = 0; dp_len = 0; dp_act = 0; dp_ok = 0;
        dp = '0;
        while ((xq.size() > 0 || dp_act) && guard < 20000) begin
            present = (gap == 0) && (xq.size() > 0);
            if (gap > 0) gap--;
            if (present) begin
                hsel   = xq[0].sel;
                htrans = xq[0].trans;
                haddr  = xq[0].addr;
                hwrite = xq[0].wr;
                hsize  = xq[0].size;
                hburst = 3'($urandom_range(0, 7));
            end else begin
                drive_idle();
            end
            fin      = dp_act && (dp_cnt == dp_len - 1);
            hwdata   = dp_act ? dp.wdata : $urandom;
            exp_rdy  = dp_act ? fin : 1'b1;
            exp_resp = (dp_act && !dp_ok) ? 2'b01 : 2'b00;
            exp_data = (fin && dp_ok && !dp.wr) ? model_read(dp) : 32'h0;
            hready   = exp_rdy;
            @(negedge clk);
            chk("hreadyout", 32'(hreadyout), 32'(exp_rdy));
            chk("hresp", 32'(hresp), 32'(exp_resp));
            chk("hrdata", hrdata, exp_data);
            if (fin && dp_ok && !dp.wr) last_rdata = hrdata;
            @(posedge clk);
            #1;
            if (dp_act) begin
                if (fin) begin
                    if (dp_ok && dp.wr) model_write(dp);
                    dp_act = 0;
                end else begin
                    dp_cnt++;
                end
            end
            if (present && exp_rdy) begin
                x   = xq.pop_front();
                gap = int'(x.gap);
                if (x.sel && x.trans[1]) begin
                    dp     = x;
                    dp_act = 1;
                    dp_cnt = 0;
                    dp_ok  = is_valid(x);
                    dp_len = dp_ok ? WS + 1 : 2;
                end
            end
            guard++;
        end
        chk("queue_drained", 32'(xq.size()) + 32'(dp_act), 32'd0);
        drive_idle();
        hready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; hmastlock = 1'b0; hwdata = 32'h0; hready = 1'b1;
        drive_idle();
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
        last_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Give the low 32 words known contents
        for (int i = 0; i < 32; i++) push(1'b1, 32'h2000_0000 + 32'(i * 4), 3'd2, $urandom, 2'd0);
        run_queue();
        init_val4 = mem_m[4];

        // Reset mid-transfer drops the pending write to 0x2000_0010
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h2000_0010; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_hreadyout", 32'(hreadyout), 32'd1);
        chk("t1_hresp", 32'(hresp), 32'd0);
        chk("t1_hrdata", hrdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        push(1'b0, 32'h2000_0010, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t1_write_dropped", last_rdata, init_val4);

        // Word write then read
        push(1'b1, 32'h2000_0004, 3'd2, 32'hDEAD_BEEF, 2'd1);
        push(1'b0, 32'h2000_0004, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t2_word", last_rdata, 32'hDEAD_BEEF);

        // Byte then half merges
        push(1'b1, 32'h2000_0006, 3'd0, 32'hA5A5_A5A5, 2'd0);
        push(1'b0, 32'h2000_0004, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t3_byte", last_rdata, 32'hDEA5_BEEF);
        push(1'b1, 32'h2000_0004, 3'd1, 32'h1234_1234, 2'd0);
        push(1'b0, 32'h2000_0004, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t3_half", last_rdata, 32'hDEA5_1234);

        // Out-of-window read and misaligned write both error; memory untouched
        push(1'b0, 32'h3000_0000, 3'd2, 32'h0, 2'd0);
        push(1'b1, 32'h2000_0002, 3'd2, 32'hFFFF_FFFF, 2'd0);
        push(1'b0, 32'h2000_0004, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t4_unchanged", last_rdata, 32'hDEA5_1234);

        // Back-to-back write/read of the same word
        t5_data = $urandom;
        push(1'b1, 32'h2000_0008, 3'd2, t5_data, 2'd0);
        push(1'b0, 32'h2000_0008, 3'd2, 32'h0, 2'd0);
        run_queue();
        chk("t5_b2b", last_rdata, t5_data);

        // BUSY with HSEL high, and NONSEQ with HSEL low: neither is taken
        begin
            xfer_t x;
            x = '0; x.sel = 1'b1; x.trans = 2'b01; x.addr = 32'h2000_0000; x.wr = 1'b1;
            xq.push_back(x);
            x.sel = 1'b0; x.trans = 2'b10;
            xq.push_back(x);
            push(1'b0, 32'h2000_0000, 3'd2, 32'h0, 2'd0);
        end
        run_queue();

        // Randomized traffic
        for (int i = 0; i < 400; i++) xq.push_back(rand_xfer());
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
